// File: rtl/dsc_pkg.sv
// Shared sizing for the deterministic stochastic-computing multiplier:
// default operand geometry, derived widths and the full stream length.
package dsc_pkg;

    localparam int DSC_DATA_WIDTH = 8;
    localparam int DSC_NUM_INPUTS = 2;

    function automatic int dsc_out_width(input int numInputs, input int dataWidth);
        return numInputs * dataWidth;
    endfunction

    // One extra bit so a parent's cycle counter can hold the full stream length itself.
    function automatic int dsc_wxip1(input int numInputs, input int dataWidth);
        return numInputs * dataWidth + 1;
    endfunction

    function automatic longint dsc_min_cycles(input int numInputs, input int dataWidth);
        return longint'(1) << (numInputs * dataWidth);
    endfunction

    localparam int     OUT_W_DEF   = dsc_out_width(DSC_NUM_INPUTS, DSC_DATA_WIDTH);
    localparam int     WXIP1_DEF   = dsc_wxip1(DSC_NUM_INPUTS, DSC_DATA_WIDTH);
    localparam longint MIN_CYC_DSC = dsc_min_cycles(DSC_NUM_INPUTS, DSC_DATA_WIDTH);

endpackage

// File: rtl/dsc_counter.sv
// Enabled wrap-around counter with a combinational overflow flag that is high
// whenever the next stride would carry out of WIDTH bits.
module dsc_counter #(
    parameter int WIDTH  = 8,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] countval,
    output logic             overflow
);

    localparam logic [WIDTH:0] STEP = (WIDTH + 1)'(STRIDE);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        sum     = {1'b0, count_q} + STEP;
        count_d = count_q;
        if (en) begin
            count_d = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign countval = count_q;
    assign overflow = sum[WIDTH];

endmodule

// File: rtl/dsc_mult_core.sv
// Deterministic stochastic-computing multiplier: clock-division unary streams
// ANDed together, ones counted. Optional DSC_EARLY_TERM_EN stops once the
// slowest stream can produce no more ones.
module dsc_mult_core
    import dsc_pkg::*;
#(
    parameter  int DATA_WIDTH = DSC_DATA_WIDTH,
    parameter  int NUM_INPUTS = DSC_NUM_INPUTS,
    localparam int OUT_W      = dsc_out_width(NUM_INPUTS, DATA_WIDTH)
) (
    input  logic                  gclk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS-1:0],
    output logic [OUT_W-1:0]      bin_data_out,
    output logic                  op_finished
);

    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] a_q;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] a_d;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] opnd;
    logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] ctrVal;
    logic [NUM_INPUTS-1:0]                 ctrEn;
    logic [NUM_INPUTS-1:0]                 ctrMax;
    logic [NUM_INPUTS-1:0]                 streamBit;
    logic                                  started_q, started_d;
    logic                                  finished_q, finished_d;
    logic [OUT_W-1:0]                      accum_q, accum_d;
    logic                                  stepEn;
    logic                                  prodBit;
    logic                                  allMax;
    logic                                  earlyDone;

    assign stepEn = en & ~finished_q;

    // The capture cycle already evaluates stream index 0, so it must see the live inputs.
    always_comb begin
        opnd = a_q;
        ctrEn = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!started_q) begin
                opnd[i] = bin_data_in[i];
            end
        end
        ctrEn[0] = stepEn;
        for (int i = 1; i < NUM_INPUTS; i++) begin
            ctrEn[i] = ctrEn[i-1] & ctrMax[i-1];
        end
    end

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ctr
        dsc_counter #(
            .WIDTH  (DATA_WIDTH),
            .STRIDE (1)
        ) u_ctr (
            .clk      (gclk),
            .rst      (rst),
            .en       (ctrEn[gi]),
            .countval (ctrVal[gi]),
            .overflow (ctrMax[gi])
        );
        assign streamBit[gi] = ctrVal[gi] < opnd[gi];
    end

    assign prodBit = &streamBit;
    assign allMax  = ctrEn[NUM_INPUTS-1] & ctrMax[NUM_INPUTS-1];

`ifdef DSC_EARLY_TERM_EN
    // Once the slowest counter reaches its operand, its stream is zero for the rest of the run.
    logic [DATA_WIDTH:0] topNext;
    assign topNext   = {1'b0, ctrVal[NUM_INPUTS-1]} + {{DATA_WIDTH{1'b0}}, ctrEn[NUM_INPUTS-1]};
    assign earlyDone = stepEn & (topNext >= {1'b0, opnd[NUM_INPUTS-1]});
`else
    assign earlyDone = 1'b0;
`endif

    always_comb begin
        a_d        = a_q;
        started_d  = started_q;
        finished_d = finished_q;
        accum_d    = accum_q;
        if (stepEn) begin
            if (!started_q) begin
                a_d       = opnd;
                started_d = 1'b1;
            end
            accum_d = accum_q + OUT_W'(prodBit);
            if (allMax || earlyDone) begin
                finished_d = 1'b1;
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            a_q        <= '0;
            started_q  <= 1'b0;
            finished_q <= 1'b0;
            accum_q    <= '0;
        end else begin
            a_q        <= a_d;
            started_q  <= started_d;
            finished_q <= finished_d;
            accum_q    <= accum_d;
        end
    end

    assign bin_data_out = accum_q;
    assign op_finished  = finished_q;

endmodule

// File: tb/tb_dsc_mult_core.sv
// Scoreboard bench for dsc_mult_core at W=4, N=2: stimulus queues the expected
// product and stream length, a negedge monitor checks them when op_finished rises.
module tb_dsc_mult_core;

    localparam int W     = 4;
    localparam int N     = 2;
    localparam int OUTW  = N * W;
    localparam int SPAN  = 1 << W;
    localparam int FULL  = 1 << (N * W);

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    logic            gclk = 1'b0;
    logic            rst  = 1'b1;
    logic            en   = 1'b0;
    logic [W-1:0]    din [N-1:0];
    logic [OUTW-1:0] dout;
    logic            fin;

    exp_t expQ[$];
    int   checks = 0;
    int   passes = 0;
    int   enCnt  = 0;
    logic prevFin = 1'b0;

    dsc_mult_core #(
        .DATA_WIDTH (W),
        .NUM_INPUTS (N)
    ) dut (
        .gclk         (gclk),
        .rst          (rst),
        .en           (en),
        .bin_data_in  (din),
        .bin_data_out (dout),
        .op_finished  (fin)
    );

    always #5 gclk = ~gclk;

    // Ones in the product stream over the first k stream indices: index t walks
    // operand 0's stream fastest (t mod 2^W) and operand 1's slowest (t div 2^W).
    function automatic int partialOnes(input int a0, input int a1, input int k);
        int n = 0;
        for (int t = 0; t < k; t++) begin
            if ((t % SPAN) < a0 && (t / SPAN) < a1) n++;
        end
        return n;
    endfunction

    function automatic int expCycles(input int a1);
`ifdef DSC_EARLY_TERM_EN
        if (a1 == 0) return 1;
        if (a1 * SPAN < FULL) return a1 * SPAN;
        return FULL;
`else
        return FULL + 0 * a1;
`endif
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    // Enabled, unfinished edges since the last reset, counted from the bench's own inputs.
    always @(posedge gclk) begin
        if (rst) enCnt <= 0;
        else if (en && !fin) enCnt <= enCnt + 1;
    end

    always @(negedge gclk) begin
        if (fin && !prevFin) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_finish", 1, 0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("product", int'(dout), e.res);
                checkOutput("latency", enCnt, e.cyc);
            end
        end
        prevFin = fin;
    end

    task automatic doReset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        tick();
        checkOutput("reset_out", int'(dout), 0);
        checkOutput("reset_fin", int'(fin), 0);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int a0, input int a1, input int pauseAt, input int pauseLen);
        int expC;
        int held;
        expC = expCycles(a1);
        doReset();
        din[0] = W'(a0);
        din[1] = W'(a1);
        expQ.push_back('{res: a0 * a1, cyc: expC});
        en = 1'b1;
        tick();
        din[0] = W'($urandom);
        din[1] = W'($urandom);
        for (int k = 1; k < expC && !fin; k++) begin
            if (k == pauseAt) begin
                checkOutput("partial", int'(dout), partialOnes(a0, a1, k));
                held = int'(dout);
                en = 1'b0;
                for (int p = 0; p < pauseLen; p++) tick();
                checkOutput("pause_hold", int'(dout), held);
                checkOutput("pause_fin", int'(fin), 0);
                en = 1'b1;
            end
            tick();
        end
        for (int c = 0; c < 8 && !fin; c++) tick();
        checkOutput("finish_timeout", int'(fin), 1);
        for (int c = 0; c < 5; c++) begin
            en = 1'($urandom);
            tick();
        end
        checkOutput("sticky_out", int'(dout), a0 * a1);
        checkOutput("sticky_fin", int'(fin), 1);
        en = 1'b0;
    endtask

    task automatic abortRun(input int a0, input int a1, input int abortAt);
        doReset();
        din[0] = W'(a0);
        din[1] = W'(a1);
        en = 1'b1;
        for (int k = 0; k < abortAt; k++) tick();
        checkOutput("abort_partial", int'(dout), partialOnes(a0, a1, abortAt));
        rst = 1'b1;
        tick();
        checkOutput("abort_out", int'(dout), 0);
        checkOutput("abort_fin", int'(fin), 0);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0, a1, ec, pa;
        din[0] = '0;
        din[1] = '0;
        applyStimulus(3, 5, 0, 0);
        applyStimulus(15, 15, 0, 0);
        applyStimulus(0, 9, 0, 0);
        applyStimulus(9, 0, 0, 0);
        applyStimulus(7, 9, 100, 20);
        abortRun(7, 9, 50);
        applyStimulus(2, 4, 0, 0);
        for (int r = 0; r < 6; r++) begin
            a0 = int'($urandom_range(0, SPAN - 1));
            a1 = int'($urandom_range(0, SPAN - 1));
            ec = expCycles(a1);
            pa = (ec > 2) ? int'($urandom_range(1, ec - 1)) : 0;
            applyStimulus(a0, a1, pa, int'($urandom_range(1, 15)));
        end
        tick();
        tick();
        checkOutput("queue_drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
